// File: rtl/bsg_nonsynth_mux_one_hot_pipelined.sv
// One-hot word select with select-vector violation tracking, followed by a
// valid/ready register pipeline with backpressure. Simulation-only helper.
module bsg_nonsynth_mux_one_hot_pipelined #(
  parameter int width_p         = 8,
  parameter int els_p           = 2,
  parameter int stages_p        = 2,
  parameter int mode_p          = 0,
  parameter int err_cnt_width_p = 8,
  parameter int fatal_p         = 0
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [els_p*width_p-1:0]   data_i,
  input  logic [els_p-1:0]           sel_one_hot_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [width_p-1:0]         data_o,
  input  logic                       yumi_i,
  output logic                       err_none_o,
  output logic                       err_multi_o,
  output logic                       err_x_o,
  output logic [err_cnt_width_p-1:0] err_count_o,
  output logic [els_p-1:0]           first_err_sel_o
);

  if (width_p < 1) begin : g_bad_width
    $fatal(1, "width_p must be >= 1");
  end
  if (els_p < 1) begin : g_bad_els
    $fatal(1, "els_p must be >= 1");
  end
  if (stages_p < 1) begin : g_bad_stages
    $fatal(1, "stages_p must be >= 1");
  end
  if ((mode_p < 0) || (mode_p > 2)) begin : g_bad_mode
    $fatal(1, "mode_p must be 0, 1 or 2");
  end

  logic [width_p-1:0] words [els_p];

  for (genvar gi = 0; gi < els_p; gi++) begin : g_unpack
    assign words[gi] = data_i[gi*width_p +: width_p];
  end

  // X/Z select bits never select a word; they only raise the x flag.
  logic [els_p-1:0]   sel_clean;
  logic [width_p-1:0] or_word, low_word, mux_word;
  logic               found, sel_multi, sel_x, sel_none;

  always_comb begin
    sel_clean = '0;
    or_word   = '0;
    low_word  = '0;
    found     = 1'b0;
    sel_multi = 1'b0;
    sel_x     = 1'b0;
    for (int i = 0; i < els_p; i++) begin
      if (sel_one_hot_i[i] === 1'b1) begin
        sel_clean[i] = 1'b1;
        or_word      = or_word | words[i];
        if (found) sel_multi = 1'b1;
        else       low_word  = words[i];
        found = 1'b1;
      end else if (sel_one_hot_i[i] !== 1'b0) begin
        sel_x = 1'b1;
      end
    end
    sel_none = !found;
    mux_word = '0;
    if (found && !sel_multi) begin
      mux_word = or_word;
    end else if (sel_multi) begin
      case (mode_p)
        0:       mux_word = or_word;
        1:       mux_word = low_word;
        default: mux_word = '0;
      endcase
    end
  end

  logic [stages_p-1:0] v_q;
  logic [width_p-1:0]  data_q [stages_p];
  logic [stages_p-1:0] adv;
  logic [stages_p-1:0] stage_in_v;
  logic [width_p-1:0]  stage_in_d [stages_p];
  logic                accept;

  // Walk from the output back: a stage advances when the one below is free.
  always_comb begin
    logic down_free;
    adv       = '0;
    down_free = yumi_i;
    for (int k = stages_p - 1; k >= 0; k--) begin
      adv[k]    = v_q[k] && down_free;
      down_free = !v_q[k] || adv[k];
    end
    ready_o = down_free;
  end

  assign accept = v_i && ready_o;

  for (genvar gi = 0; gi < stages_p; gi++) begin : g_stage_in
    if (gi == 0) begin : g_head
      assign stage_in_v[gi] = accept;
      assign stage_in_d[gi] = mux_word;
    end else begin : g_body
      assign stage_in_v[gi] = adv[gi-1];
      assign stage_in_d[gi] = data_q[gi-1];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < stages_p; k++) begin
      if (!reset_n_i) begin
        v_q[k]    <= 1'b0;
        data_q[k] <= '0;
      end else if (!v_q[k] || adv[k]) begin
        v_q[k] <= stage_in_v[k];
        if (stage_in_v[k]) data_q[k] <= stage_in_d[k];
      end
    end
  end

  assign v_o    = v_q[stages_p-1];
  assign data_o = data_q[stages_p-1];

  logic                       err_none_q, err_multi_q, err_x_q;
  logic [err_cnt_width_p-1:0] err_cnt_q, err_cnt_d;
  logic [els_p-1:0]           first_sel_q;
  logic                       viol;

  assign viol      = sel_none || sel_multi || sel_x;
  assign err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      err_none_q  <= 1'b0;
      err_multi_q <= 1'b0;
      err_x_q     <= 1'b0;
      err_cnt_q   <= '0;
      first_sel_q <= '0;
    end else if (accept && viol) begin
      err_none_q  <= err_none_q  || sel_none;
      err_multi_q <= err_multi_q || sel_multi;
      err_x_q     <= err_x_q     || sel_x;
      err_cnt_q   <= err_cnt_d;
      // The counter never wraps, so zero means no violation has been seen.
      if (err_cnt_q == '0) first_sel_q <= sel_clean;
    end
  end

  assign err_none_o      = err_none_q;
  assign err_multi_o     = err_multi_q;
  assign err_x_o         = err_x_q;
  assign err_count_o     = err_cnt_q;
  assign first_err_sel_o = first_sel_q;

`ifndef SYNTHESIS
  initial $display("%m: bsg_nonsynth_mux_one_hot_pipelined is non-synthesizable");

  always @(posedge clk_i) begin
    if (reset_n_i && accept && viol) begin
      $warning("%m: t=%0t sel=%b class=%s%s%s", $time, sel_one_hot_i,
               sel_none ? "none " : "", sel_multi ? "multi " : "", sel_x ? "x" : "");
      if (fatal_p != 0) begin
        $error("%m: select violation with fatal_p set");
        $finish;
      end
    end
    if (reset_n_i && yumi_i && !v_o)
      $error("%m: t=%0t yumi_i asserted while v_o=0", $time);
  end
`endif

endmodule
